// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state type and legal WIDTH bounds for the bit-serial subtractor
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
    localparam int SUB_WIDTH_MIN = 2;
    localparam int SUB_WIDTH_MAX = 32;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtract cell with borrow in/out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b using one full_subtractor and a borrow flip-flop
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);

    sub_state_t       state;
    logic [WIDTH-1:0] sr_a, sr_b, sr_d, nd;
    logic [CW-1:0]    cnt;
    logic             bf, d, bout;

    full_subtractor u_fs (
        .a    (sr_a[0]),
        .b    (sr_b[0]),
        .bin  (bf),
        .d    (d),
        .bout (bout)
    );

    assign nd = {d, sr_d[WIDTH-1:1]};

    // FSM: load operands on start, shift one bit per cycle, publish result with a one-cycle done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr_a   <= '0;
            sr_b   <= '0;
            sr_d   <= '0;
            cnt    <= '0;
            bf     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr_a  <= a;
                        sr_b  <= b;
                        bf    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_a <= sr_a >> 1;
                    sr_b <= sr_b >> 1;
                    sr_d <= nd;
                    bf   <= bout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff   <= nd;
                        borrow <= bout;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    logic fa, fb, fbin, fd, fbout;

    int vectors = 0;
    int miscompares = 0;

    int           age = -1;
    logic [W-1:0] ma = '0, mb = '0, ed = '0;
    logic         eb = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    full_subtractor u_cell (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an operation accepted in idle completes W edges later; a completed result is (a-b) mod 2^W
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age = -1;
            ed  = '0;
            eb  = 1'b0;
        end else if (age < 0) begin
            if (start) begin
                age = 0;
                ma  = a;
                mb  = b;
            end
        end else if (age == W) begin
            age = -1;
        end else begin
            age++;
            if (age == W) begin
                ed = ma - mb;
                eb = (ma < mb);
            end
        end
    end

    // Compare every cycle while out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(age >= 0));
            chk("done", 32'(done), 32'(age == W));
            chk("diff", 32'(diff), 32'(ed));
            chk("borrow", 32'(borrow), 32'(eb));
        end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] ld, input logic lb);
        int n;
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            n++;
        end
        chk("latency", 32'(n), 32'(W + 1));
        chk("lit_diff", 32'(diff), 32'(ld));
        chk("lit_borrow", 32'(borrow), 32'(lb));
        @(negedge clk);
    endtask

    initial begin
        int last, gaps;
        logic signed [2:0] t;
        for (int i = 0; i < 8; i++) begin
            {fa, fb, fbin} = 3'(i);
            #1;
            t = $signed({2'b0, fa}) - $signed({2'b0, fb}) - $signed({2'b0, fbin});
            chk("cell_d", 32'(fd), 32'(t[0]));
            chk("cell_bout", 32'(fbout), 32'(t < 0));
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op(8'h05, 8'h03, 8'h02, 1'b0);
        op(8'h03, 8'h05, 8'hFE, 1'b1);
        op(8'h00, 8'hFF, 8'h01, 1'b1);
        op(8'hA5, 8'hA5, 8'h00, 1'b0);
        op(8'hFF, 8'h00, 8'hFF, 1'b0);
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        last = -1;
        gaps = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (done) begin
                chk("held_diff", 32'(diff), 32'h0F);
                if (last >= 0) chk("held_period", 32'(c - last), 32'd10);
                last = c;
                gaps++;
            end
        end
        chk("held_count", 32'(gaps), 32'd3);
        start = 1'b0;
        while (busy) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'h33;
        b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_diff", 32'(diff), 32'd0);
        chk("async_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gaps = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) gaps++;
        end
        chk("no_done_after_rst", 32'(gaps), 32'd0);
        op(8'h40, 8'h41, 8'hFF, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
